button_ctrl: RTL
================

BUTTON_CTRL -- requirements
Module: button_ctrl

Interface
REQ-001 Parameter N_BTN, default 4, number of button inputs (1..8).
REQ-002 Parameter TICK_DIV, default 100000, clock cycles per sample tick (1 ms at 100 MHz).
REQ-003 Parameter STABLE_TICKS, default 10, consecutive stable ticks needed to change a clean level.
REQ-004 Parameter LONG_TICKS, default 1000, ticks held in PRESSED before a long-press event.
REQ-005 clock  input  1  system clock, all logic on posedge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 noisy  input  N_BTN  raw, asynchronous button levels, 1 = pressed.
REQ-008 clean  output  N_BTN  debounced levels.
REQ-009 evt_valid  output  1  event FIFO head valid.
REQ-010 evt_ready  input  1  consumer accepts the head when it is high in the same cycle as evt_valid.
REQ-011 evt_btn  output  3  button index of the head event.
REQ-012 evt_type  output  2  head event type: 0 PRESS, 1 RELEASE, 2 LONG.
REQ-013 overflow  output  1  sticky flag indicating an event was lost.

Function
REQ-014 Each noisy bit SHALL pass through a 2-flop synchronizer before any use.
REQ-015 One shared divider SHALL pulse tick for 1 cycle every TICK_DIV cycles; all buttons sample only on tick.
REQ-016 Per-button FSM states: RELEASED, DEB_PRESS, PRESSED, DEB_RELEASE.
REQ-017 RELEASED to DEB_PRESS on a tick with sync=1, and the counter clears.
REQ-018 In DEB_PRESS, each tick with sync=1 increments the counter. A tick with sync=0 returns to RELEASED.
REQ-019 When the counter reaches STABLE_TICKS, the FSM enters PRESSED, sets clean=1, raises PRESS pending, and clears the counter.
REQ-020 DEB_RELEASE/PRESSED mirror REQ-017 to REQ-019 with polarity inverted. On reaching STABLE_TICKS: clean=0, RELEASE pending.
REQ-021 In PRESSED the counter counts ticks up to LONG_TICKS, raises LONG pending exactly once per press, then saturates.
REQ-022 A transition from PRESSED to DEB_RELEASE freezes the long count. A return to PRESSED resumes it, and a bounce does not rearm LONG.
REQ-023 Per-button counters SHALL be wide enough for max(STABLE_TICKS, LONG_TICKS) with no wrap-around.
REQ-024 Pending flags: one per button per type.
REQ-025 Each cycle the arbiter selects the lowest (button, type) pending flag, ordered by button index first and then PRESS<RELEASE<LONG. It pushes that flag if the FIFO is not full or a pop occurs in the same cycle.
REQ-026 A pushed flag clears in the same cycle.
REQ-027 If a flag is raised while already set, overflow SHALL set and stay set until reset.
REQ-028 FIFO: 8 entries, first-word fall-through. Pop when evt_valid&&evt_ready. A push and a pop in the same cycle with the FIFO full SHALL both succeed.
REQ-029 clean latency: 2 sync cycles + STABLE_TICKS ticks + 1 cycle. The event appears on evt_valid no earlier than 1 cycle after clean changes.
REQ-030 evt_btn, evt_type SHALL hold stable while evt_valid=1 and evt_ready=0.

Reset
REQ-031 Reset values: clean=0, evt_valid=0, evt_btn=0, evt_type=0, overflow=0.
REQ-032 On reset the FIFO, pending flags, divider, counters and synchronizers clear, and every FSM enters RELEASED.
REQ-033 Reset mid-press: after release of reset, a button still held SHALL be re-debounced and produce a fresh PRESS.

Configuration
REQ-034 Macro BUTTON_CTRL_LONG_PRESS_EN defined: REQ-021/022 are active and LONG events are generated.
REQ-035 Macro undefined: the long-count logic and LONG flags are not built, and evt_type never equals 2. The PRESSED counter does not count.

Structure
REQ-036 Package button_ctrl_pkg SHALL hold the evt_type enum (PRESS/RELEASE/LONG), the FSM state enum and the FIFO depth constant.
REQ-037 Sub-module btn_evt_fifo SHALL contain the 8-entry FIFO. All other logic stays in button_ctrl.

Verification
REQ-038 TICK_DIV=4, STABLE_TICKS=3: noisy[0] rises cleanly -> clean[0]=1 after 2+12+1 cycles, then a PRESS event for btn 0.
REQ-039 noisy[1] toggles every 5 cycles for 200 cycles, then holds 1 -> a single PRESS, no RELEASE, clean[1] glitch-free.
REQ-040 Buttons 2 and 0 finish debounce on the same tick -> events ordered btn0 PRESS, then btn2 PRESS.
REQ-041 evt_ready=0, 9 events generated -> 8 in FIFO, overflow stays 0 while pending flags hold. Raise a duplicate flag -> overflow=1.
REQ-042 LONG_TICKS=20 with the macro defined: hold 25 ticks -> PRESS then a single LONG. Without the macro: PRESS only.
REQ-043 Assert reset while clean[3]=1 and noisy held -> clean=0, FIFO empty, then a fresh PRESS after debounce.

Source files
------------

// File: rtl/button_ctrl_pkg.sv
// button_ctrl_pkg: event type and debounce state enums plus event FIFO depth shared by button_ctrl and btn_evt_fifo
package button_ctrl_pkg;
  typedef enum logic [1:0] {EVT_PRESS = 2'd0, EVT_RELEASE = 2'd1, EVT_LONG = 2'd2} evt_type_e;
  typedef enum logic [1:0] {RELEASED, DEB_PRESS, PRESSED, DEB_RELEASE} btn_state_e;
  localparam int FIFO_DEPTH = 8;
endpackage

// File: rtl/btn_evt_fifo.sv
// btn_evt_fifo: FIFO_DEPTH-entry first-word-fall-through event queue (clock, reset, push/din in, pop in, dout/valid/full out; dout reads 0 when empty; push and pop together succeed when full)
module btn_evt_fifo
  import button_ctrl_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  assign valid = cnt_q != '0;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign dout = valid ? mem_q[rd_q] : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/button_ctrl.sv
// button_ctrl: synchronize, debounce and queue PRESS/RELEASE(/LONG with BUTTON_CTRL_LONG_PRESS_EN) events for N_BTN buttons (clock, reset, noisy in, clean out, evt_valid/evt_ready/evt_btn/evt_type handshake, sticky overflow)
module button_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int TICK_DIV = 100000,
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] noisy,
  output logic [N_BTN-1:0] clean,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_btn,
  output logic [1:0]       evt_type,
  output logic             overflow
);
`ifdef BUTTON_CTRL_LONG_PRESS_EN
  localparam int NT = 3;
`else
  localparam int NT = 2;
`endif
  localparam int CMAX = STABLE_TICKS > LONG_TICKS ? STABLE_TICKS : LONG_TICKS;
  localparam int CW = $clog2(CMAX + 1);
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int NP = N_BTN * NT;
  logic [N_BTN-1:0] meta_q, sync_q, clean_q, clean_d;
  logic [DW-1:0] div_q, div_d;
  logic tick;
  btn_state_e st_q [N_BTN];
  btn_state_e st_d [N_BTN];
  logic [CW-1:0] cnt_q [N_BTN];
  logic [CW-1:0] cnt_d [N_BTN];
`ifdef BUTTON_CTRL_LONG_PRESS_EN
  logic [CW-1:0] lcnt_q [N_BTN];
  logic [CW-1:0] lcnt_d [N_BTN];
`endif
  logic [NP-1:0] pend_q, pend_d, raise, sel, clr;
  logic overflow_q, overflow_d, found, push, pop, full;
  logic [4:0] din, dout;
  assign tick = div_q == DW'(TICK_DIV - 1);
  assign div_d = tick ? '0 : div_q + 1'b1;
  always_comb begin
    raise = '0;
    for (int b = 0; b < N_BTN; b++) begin
      st_d[b] = st_q[b];
      cnt_d[b] = cnt_q[b];
      clean_d[b] = clean_q[b];
`ifdef BUTTON_CTRL_LONG_PRESS_EN
      lcnt_d[b] = lcnt_q[b];
`endif
      if (tick) begin
        case (st_q[b])
          RELEASED: begin
            if (sync_q[b]) begin
              st_d[b] = DEB_PRESS;
              cnt_d[b] = '0;
            end
          end
          DEB_PRESS: begin
            if (!sync_q[b]) st_d[b] = RELEASED;
            else if (cnt_q[b] == CW'(STABLE_TICKS - 1)) begin
              st_d[b] = PRESSED;
              cnt_d[b] = '0;
              clean_d[b] = 1'b1;
              raise[b*NT + int'(EVT_PRESS)] = 1'b1;
`ifdef BUTTON_CTRL_LONG_PRESS_EN
              lcnt_d[b] = '0;
`endif
            end else cnt_d[b] = cnt_q[b] + 1'b1;
          end
          PRESSED: begin
            if (!sync_q[b]) begin
              st_d[b] = DEB_RELEASE;
              cnt_d[b] = '0;
            end
`ifdef BUTTON_CTRL_LONG_PRESS_EN
            else if (lcnt_q[b] != CW'(LONG_TICKS)) begin
              lcnt_d[b] = lcnt_q[b] + 1'b1;
              raise[b*NT + int'(EVT_LONG)] = lcnt_q[b] == CW'(LONG_TICKS - 1);
            end
`endif
          end
          DEB_RELEASE: begin
            if (sync_q[b]) st_d[b] = PRESSED;
            else if (cnt_q[b] == CW'(STABLE_TICKS - 1)) begin
              st_d[b] = RELEASED;
              cnt_d[b] = '0;
              clean_d[b] = 1'b0;
              raise[b*NT + int'(EVT_RELEASE)] = 1'b1;
            end else cnt_d[b] = cnt_q[b] + 1'b1;
          end
        endcase
      end
    end
  end
  assign pop = evt_valid && evt_ready;
  always_comb begin
    found = 1'b0;
    sel = '0;
    din = '0;
    for (int i = 0; i < NP; i++) begin
      if (!found && pend_q[i]) begin
        found = 1'b1;
        sel[i] = 1'b1;
        din = {3'(i / NT), 2'(i % NT)};
      end
    end
    push = found && (!full || pop);
    clr = push ? sel : '0;
    pend_d = (pend_q & ~clr) | raise;
    overflow_d = overflow_q || |(raise & pend_q & ~clr);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      div_q <= '0;
      clean_q <= '0;
      pend_q <= '0;
      overflow_q <= 1'b0;
      for (int b = 0; b < N_BTN; b++) begin
        st_q[b] <= RELEASED;
        cnt_q[b] <= '0;
`ifdef BUTTON_CTRL_LONG_PRESS_EN
        lcnt_q[b] <= '0;
`endif
      end
    end else begin
      meta_q <= noisy;
      sync_q <= meta_q;
      div_q <= div_d;
      clean_q <= clean_d;
      pend_q <= pend_d;
      overflow_q <= overflow_d;
      for (int b = 0; b < N_BTN; b++) begin
        st_q[b] <= st_d[b];
        cnt_q[b] <= cnt_d[b];
`ifdef BUTTON_CTRL_LONG_PRESS_EN
        lcnt_q[b] <= lcnt_d[b];
`endif
      end
    end
  end
  btn_evt_fifo #(.W(5)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .din(din),
    .pop(pop),
    .dout(dout),
    .valid(evt_valid),
    .full(full)
  );
  assign clean = clean_q;
  assign overflow = overflow_q;
  assign evt_btn = dout[4:2];
  assign evt_type = dout[1:0];
endmodule
